// File: rtl/ctrl_pkg.sv
// ctrl_pkg: constants shared by the multi-cycle controller and its ALU.
// Opcodes, FSM state encoding and register-bank destination codes.
package ctrl_pkg;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDI = 4'h1;
    localparam logic [3:0] OP_MOV = 4'h2;
    localparam logic [3:0] OP_ADD = 4'h3;
    localparam logic [3:0] OP_SUB = 4'h4;
    localparam logic [3:0] OP_AND = 4'h5;
    localparam logic [3:0] OP_OR  = 4'h6;
    localparam logic [3:0] OP_XOR = 4'h7;
    localparam logic [3:0] OP_JMP = 4'h8;
    localparam logic [3:0] OP_JZ  = 4'h9;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [1:0] REG_A = 2'b00;
    localparam logic [1:0] REG_B = 2'b01;

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_FETCH_IMM = 3'd2,
        S_IMM       = 3'd3,
        S_EXEC      = 3'd4,
        S_WB        = 3'd5,
        S_HALT      = 3'd6
    } state_t;

    // Instructions carrying a second (immediate) byte
    function automatic logic hasImm(input logic [3:0] op);
        return (op == OP_LDI) || (op == OP_JMP) || (op == OP_JZ);
    endfunction

endpackage

// File: rtl/ula_8bits.sv
// ula_8bits: combinational 8-bit ALU for the controller.
// Produces result, zero flag and carry/borrow flag.
module ula_8bits
    import ctrl_pkg::*;
(
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [3:0] op,
    output logic [7:0] result,
    output logic       z,
    output logic       c
);

    logic [8:0] wide;

    // 9-bit datapath: ADD carry and SUB borrow both land in bit 8
    always_comb begin
        wide = 9'd0;
        unique case (op)
            OP_ADD:  wide = {1'b0, a} + {1'b0, b};
            OP_SUB:  wide = {1'b0, a} - {1'b0, b};
            OP_AND:  wide = {1'b0, a & b};
            OP_OR:   wide = {1'b0, a | b};
            OP_XOR:  wide = {1'b0, a ^ b};
            default: wide = 9'd0;
        endcase
    end

    assign result = wide[7:0];
    assign c      = wide[8];
    assign z      = (wide[7:0] == 8'd0);

endmodule

// File: rtl/unidade_controle.sv
// unidade_controle: multi-cycle fetch/decode/execute controller.
// Owns PC, IR, immediate and Z/C flags; drives the A/B register bank.
module unidade_controle
    import ctrl_pkg::*;
#(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
)(
    input  logic            clk,
    input  logic            reset,
    input  logic            run,
    output logic [PC_W-1:0] mem_addr,
    input  logic [7:0]      mem_data,
    input  logic [7:0]      regA_in,
    input  logic [7:0]      regB_in,
    output logic            rf_write,
    output logic [1:0]      rf_dest,
    output logic [7:0]      rf_wrData,
    output logic            flag_z,
    output logic            flag_c,
    output logic            halted
);

    localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

    state_t          state;
    state_t          stateNext;
    logic [PC_W-1:0] pc;
    logic [7:0]      ir;
    logic [7:0]      imm;

    logic [3:0]      opcode;
    logic [1:0]      rd;
    logic [7:0]      aluRes;
    logic            aluZ;
    logic            aluC;
    logic [7:0]      execData;
    logic            writesReg;
    logic            isAluOp;
    logic            unusedIrBits;

    assign opcode       = ir[7:4];
    assign rd           = ir[3:2];
    // Operand bits [1:0] carry no meaning in this ISA
    assign unusedIrBits = ^ir[1:0];

    assign isAluOp   = (opcode >= OP_ADD) && (opcode <= OP_XOR);
    assign writesReg = (opcode >= OP_LDI) && (opcode <= OP_XOR) && !rd[1];

    assign mem_addr = pc;
    assign halted   = (state == S_HALT);

    ula_8bits u_ula (
        .a      (regA_in),
        .b      (regB_in),
        .op     (opcode),
        .result (aluRes),
        .z      (aluZ),
        .c      (aluC)
    );

    // Select the value written back: immediate, other register or ALU
    always_comb begin
        execData = aluRes;
        if (opcode == OP_LDI) begin
            execData = imm;
        end else if (opcode == OP_MOV) begin
            execData = (rd == REG_A) ? regB_in : regA_in;
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_FETCH;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state sequencing through fetch, decode, execute, write-back
    always_comb begin
        stateNext = state;
        unique case (state)
            S_FETCH:     if (run) stateNext = S_DECODE;
            S_DECODE:    stateNext = hasImm(mem_data[7:4]) ? S_FETCH_IMM : S_EXEC;
            S_FETCH_IMM: stateNext = S_IMM;
            S_IMM:       stateNext = S_EXEC;
            S_EXEC:      stateNext = (opcode == OP_HLT) ? S_HALT : S_WB;
            S_WB:        stateNext = S_FETCH;
            S_HALT:      stateNext = S_HALT;
            default:     stateNext = S_FETCH;
        endcase
    end

    // PC, instruction/immediate capture, flags and bank write port
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc        <= RESET_PC;
            ir        <= 8'd0;
            imm       <= 8'd0;
            rf_write  <= 1'b0;
            rf_dest   <= REG_A;
            rf_wrData <= 8'd0;
            flag_z    <= 1'b0;
            flag_c    <= 1'b0;
        end else begin
            unique case (state)
                S_DECODE: begin
                    ir <= mem_data;
                    pc <= pc + PC_ONE;
                end
                S_IMM: begin
                    imm <= mem_data;
                    pc  <= pc + PC_ONE;
                end
                S_EXEC: begin
                    rf_wrData <= execData;
                    rf_dest   <= rd;
                    rf_write  <= writesReg;
                    if (isAluOp) begin
                        flag_z <= aluZ;
                        flag_c <= aluC;
                    end
                    if (opcode == OP_JMP) begin
                        pc <= PC_W'(imm);
                    end else if (opcode == OP_JZ && flag_z) begin
                        pc <= PC_W'(imm);
                    end
                end
                S_WB: begin
                    rf_write <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_unidade_controle.sv
// tb_unidade_controle: scoreboard bench for the multi-cycle controller.
// An ISA-level reference model predicts bank writes and the halt point.
module tb_unidade_controle;

    typedef struct {
        int cyc;
        int dest;
        int data;
        int flags;
    } wr_t;

    typedef struct {
        int cyc;
        int pc;
        int flags;
    } halt_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       run = 1'b0;
    logic [7:0] mem_addr;
    logic [7:0] mem_data;
    logic [7:0] bankA;
    logic [7:0] bankB;
    logic [7:0] presetA;
    logic [7:0] presetB;
    logic       loadBank = 1'b0;
    logic       rf_write;
    logic [1:0] rf_dest;
    logic [7:0] rf_wrData;
    logic       flag_z;
    logic       flag_c;
    logic       halted;

    logic [7:0] mem [256];

    wr_t   wq[$];
    halt_t hq[$];
    wr_t   wEv;
    halt_t hEv;

    int   cyc;
    int   total = 0;
    int   bad = 0;
    int   haltCount = 0;
    int   haltBase = 0;
    logic prevHalted = 1'b0;

    unidade_controle dut (
        .clk       (clk),
        .reset     (reset),
        .run       (run),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .regA_in   (bankA),
        .regB_in   (bankB),
        .rf_write  (rf_write),
        .rf_dest   (rf_dest),
        .rf_wrData (rf_wrData),
        .flag_z    (flag_z),
        .flag_c    (flag_c),
        .halted    (halted)
    );

    always #5 clk = ~clk;

    // Synchronous program memory: one cycle read latency
    always @(posedge clk) mem_data <= mem[mem_addr];

    // Register bank downstream of the controller
    always @(posedge clk) begin
        if (loadBank) begin
            bankA <= presetA;
            bankB <= presetB;
        end else if (rf_write) begin
            if (rf_dest == 2'b00) bankA <= rf_wrData;
            else if (rf_dest == 2'b01) bankB <= rf_wrData;
        end
    end

    // Cycles since reset release
    always @(posedge clk or negedge reset) begin
        if (!reset) cyc <= 0;
        else cyc <= cyc + 1;
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops expectations whenever the DUT writes or halts
    always @(negedge clk) begin
        if (reset) begin
            if (rf_write) begin
                if (wq.size() == 0) begin
                    check("wr_unexpected", int'(rf_write), 0);
                end else begin
                    wEv = wq.pop_front();
                    check("wr_cycle", cyc, wEv.cyc);
                    check("wr_dest", int'(rf_dest), wEv.dest);
                    check("wr_data", int'(rf_wrData), wEv.data);
                    check("wr_flags", int'({flag_z, flag_c}), wEv.flags);
                end
            end
            if (halted && !prevHalted) begin
                haltCount <= haltCount + 1;
                if (hq.size() == 0) begin
                    check("halt_unexpected", int'(halted), 0);
                end else begin
                    hEv = hq.pop_front();
                    check("halt_cycle", cyc, hEv.cyc);
                    check("halt_pc", int'(mem_addr), hEv.pc);
                    check("halt_flags", int'({flag_z, flag_c}), hEv.flags);
                end
            end
        end
        prevHalted <= halted;
    end

    // Instruction-level reference: walks the program and predicts events
    task automatic model(input int startCyc, input logic [7:0] a0, input logic [7:0] b0);
        logic [7:0] pc, a, b, ins, imm, res;
        logic [1:0] rd;
        logic       z, c, wr;
        int         t, len, op, s;
        pc = 8'h00; a = a0; b = b0; z = 1'b0; c = 1'b0; t = startCyc;
        for (int n = 0; n < 300; n++) begin
            ins = mem[pc];
            pc = pc + 8'd1;
            op = int'(ins[7:4]);
            rd = ins[3:2];
            imm = 8'h00;
            len = 4;
            if (op == 1 || op == 8 || op == 9) begin
                imm = mem[pc];
                pc = pc + 8'd1;
                len = 6;
            end
            wr = 1'b0;
            res = 8'h00;
            case (op)
                1: begin res = imm; wr = 1'b1; end
                2: begin res = (rd == 2'b00) ? b : a; wr = 1'b1; end
                3: begin
                    s = int'(a) + int'(b);
                    res = s[7:0]; c = (s > 255); z = (res == 0); wr = 1'b1;
                end
                4: begin res = a - b; c = (a < b); z = (res == 0); wr = 1'b1; end
                5: begin res = a & b; c = 1'b0; z = (res == 0); wr = 1'b1; end
                6: begin res = a | b; c = 1'b0; z = (res == 0); wr = 1'b1; end
                7: begin res = a ^ b; c = 1'b0; z = (res == 0); wr = 1'b1; end
                8: pc = imm;
                9: if (z) pc = imm;
                15: begin
                    hq.push_back('{t + 3, int'(pc), int'({z, c})});
                    return;
                end
                default: ;
            endcase
            if (wr && !rd[1]) begin
                wq.push_back('{t + len - 1, int'(rd), int'(res), int'({z, c})});
                if (rd == 2'b00) a = res;
                else b = res;
            end
            t += len;
        end
    endtask

    task automatic newTest();
        reset = 1'b0;
        run = 1'b0;
        #1;
        wq.delete();
        hq.delete();
        haltBase = haltCount;
        for (int i = 0; i < 256; i++) mem[i] = 8'hF0;
    endtask

    task automatic startProg(input bit hold);
        reset = 1'b0;
        loadBank = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        loadBank = 1'b0;
        reset = 1'b1;
        run = hold ? 1'b0 : 1'b1;
        #1;
        check("pc_after_release", int'(mem_addr), 0);
        if (hold) begin
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                #1;
                check("hold_addr", int'(mem_addr), 0);
                check("hold_idle", int'({halted, rf_write}), 0);
            end
            run = 1'b1;
        end
    endtask

    task automatic waitHalt();
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            #1;
            if (haltCount > haltBase) break;
        end
        check("halt_reached", haltCount - haltBase, 1);
        check("wr_queue_empty", wq.size(), 0);
        for (int i = 0; i < 3; i++) begin
            run = 1'($urandom_range(0, 1));
            @(negedge clk);
            #1;
            check("halt_hold", int'(halted), 1);
        end
    endtask

    task automatic genRandom();
        int n, a, j;
        int addr[12];
        logic [7:0] ops[12];
        logic [3:0] op;
        n = $urandom_range(4, 11);
        a = 0;
        for (int i = 0; i < n; i++) begin
            if (i == n - 1) begin
                op = 4'hF;
            end else begin
                op = 4'($urandom_range(0, 14));
            end
            ops[i] = {op, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
            addr[i] = a;
            a += (op == 4'h1 || op == 4'h8 || op == 4'h9) ? 2 : 1;
        end
        for (int i = 0; i < n; i++) begin
            mem[addr[i]] = ops[i];
            if (ops[i][7:4] == 4'h1) begin
                mem[addr[i] + 1] = 8'($urandom_range(0, 255));
            end else if (ops[i][7:4] == 4'h8 || ops[i][7:4] == 4'h9) begin
                j = $urandom_range(i + 1, n - 1);
                mem[addr[i] + 1] = 8'(addr[j]);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'hF0;
        presetA = 8'h00;
        presetB = 8'h00;
        #2;
        reset = 1'b0;
        #1;
        check("rst_write", int'(rf_write), 0);
        check("rst_dest", int'(rf_dest), 0);
        check("rst_data", int'(rf_wrData), 0);
        check("rst_flags", int'({flag_z, flag_c}), 0);
        check("rst_halted", int'(halted), 0);
        check("rst_addr", int'(mem_addr), 0);

        // LDI A,5 ; LDI B,3 ; ADD A ; HLT with hand-derived expectations
        newTest();
        mem[0] = 8'h10; mem[1] = 8'h05; mem[2] = 8'h14;
        mem[3] = 8'h03; mem[4] = 8'h30; mem[5] = 8'hF0;
        presetA = 8'h00; presetB = 8'h00;
        wq.push_back('{5, 0, 'h05, 0});
        wq.push_back('{11, 1, 'h03, 0});
        wq.push_back('{15, 0, 'h08, 0});
        hq.push_back('{19, 'h06, 0});
        startProg(1'b0);
        waitHalt();

        // ADD overflow to zero, then taken JZ to 40
        newTest();
        mem[0] = 8'h30; mem[1] = 8'h90; mem[2] = 8'h40;
        presetA = 8'hFF; presetB = 8'h01;
        model(0, presetA, presetB);
        startProg(1'b0);
        waitHalt();

        // SUB with borrow into B, then flag-only XOR
        newTest();
        mem[0] = 8'h44; mem[1] = 8'h7C; mem[2] = 8'hF0;
        presetA = 8'h03; presetB = 8'h05;
        model(0, presetA, presetB);
        startProg(1'b0);
        waitHalt();

        // run held low for 20 cycles
        newTest();
        mem[0] = 8'h30;
        presetA = 8'h12; presetB = 8'h34;
        model(19, presetA, presetB);
        startProg(1'b1);
        waitHalt();

        // Reset asserted in the write-back cycle of an ADD
        newTest();
        mem[0] = 8'h30;
        presetA = 8'hFF; presetB = 8'h01;
        model(0, presetA, presetB);
        startProg(1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            if (rf_write) break;
        end
        check("wb_reached", int'(rf_write), 1);
        #1;
        reset = 1'b0;
        #1;
        check("wb_rst_write", int'(rf_write), 0);
        check("wb_rst_addr", int'(mem_addr), 0);
        check("wb_rst_flags", int'({flag_z, flag_c}), 0);
        check("wb_rst_halted", int'(halted), 0);
        newTest();
        mem[0] = 8'h30;
        model(0, presetA, presetB);
        startProg(1'b0);
        waitHalt();

        // Undefined opcode, then JMP whose immediate sits at FF
        newTest();
        mem[0] = 8'h80; mem[1] = 8'hFD;
        mem[8'hFD] = 8'hB0; mem[8'hFE] = 8'h80; mem[8'hFF] = 8'h10;
        mem[8'h10] = 8'h34; mem[8'h11] = 8'hF0;
        presetA = 8'h21; presetB = 8'h42;
        model(0, presetA, presetB);
        startProg(1'b0);
        waitHalt();

        // Random forward-only programs
        for (int r = 0; r < 10; r++) begin
            newTest();
            genRandom();
            presetA = 8'($urandom_range(0, 255));
            presetB = 8'($urandom_range(0, 255));
            model(0, presetA, presetB);
            startProg(1'b0);
            waitHalt();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
